falu_issue_ctrl: RTL and testbench
==================================

# falu_issue_ctrl

Execute-stage sequencer for the multi-cycle floating-point ALU (FALU). It accepts one FP operation from E and issues a start pulse. It holds the front of the pipeline with a stall for the operation's latency, then selects the FALU result onto the E-stage result path (E_alu_falu_sel) for exactly one cycle. It also exposes the pending destination register to the hazard logic and counts FALU-induced stall cycles.

## Interface
Parameters:
- LAT_ADD, 3: FADD/FSUB latency in cycles, minimum 1
- LAT_MUL, 4: FMUL latency
- LAT_DIV, 12: FDIV latency
- LAT_SQRT, 16: FSQRT latency
- LAT_MISC, 1: compare, move, sign-inject and illegal op latency
- CNT_W, 5: latency counter width; must hold max(LAT_*)-1

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- E_falu_req  in  1  valid FP instruction in E
- E_falu_op  in  3  000 add, 001 sub, 010 mul, 011 div, 100 sqrt, 101 misc, 110/111 illegal (treated as misc)
- E_rd  in  5  FP destination of the E instruction
- flush  in  1  kill the E-stage instruction this cycle
- falu_start  out  1  one-cycle issue pulse to FALU
- falu_op_q  out  3  latched op, held stable from the cycle after start to the end of DONE
- falu_abort  out  1  one-cycle pulse when an in-flight operation is killed
- stall  out  1  freeze PC, F/D and D/E registers
- E_alu_falu_sel  out  1  1 = integer ALU result, 0 = FALU result
- pend_valid  out  1  FP destination pending (RUN or DONE)
- pend_rd  out  5  pending destination register
- stall_cycles  out  32  saturating count of cycles with stall=1

## Operation
- States: IDLE, RUN, DONE.
- Latency L for each op is taken from the LAT_* parameters. The counter cnt is CNT_W bits wide.
- IDLE:
  - If E_falu_req & !flush: assert falu_start, latch op into falu_op_q and E_rd into pend_rd, and load cnt = L-1.
  - Next state is RUN if L>1, else DONE.
  - If flush is asserted, do not issue and stay in IDLE.
- RUN:
  - If flush: pulse falu_abort and go to IDLE.
  - Else if cnt==1 or cnt==0: go to DONE.
  - Else decrement cnt.
- DONE:
  - E_alu_falu_sel=0.
  - Unconditionally return to IDLE. Do not re-examine E_falu_req in this cycle; it still belongs to the completing instruction.
  - flush in DONE also returns to IDLE, and the result is discarded downstream.
- Combinational outputs:
  - stall = (IDLE & E_falu_req & !flush) | (RUN & !flush)
  - E_alu_falu_sel = !(state==DONE)
  - pend_valid = (RUN | DONE)
- stall_cycles increments when stall=1 and saturates at 32'hFFFFFFFF.
- E_falu_req during RUN belongs to the same instruction and is ignored.

## Timing
- Issue at cycle t (IDLE, req=1):
  - stall is high for cycles t..t+L-1, i.e. L cycles.
  - DONE occurs at cycle t+L with stall=0 and sel=0.
  - The pipeline advances at the end of cycle t+L.
- Back-to-back FP ops: the next op is issued at cycle t+L+1, with no bubble beyond the IDLE cycle.
- Reset values: state=IDLE, cnt=0, falu_op_q=0, pend_rd=0, stall_cycles=0. Derived outputs at reset: falu_start=0, falu_abort=0, stall=0, E_alu_falu_sel=1, pend_valid=0.
- Reset asserted mid-RUN: return to IDLE immediately (asynchronous). No abort pulse. stall drops without waiting for a clock edge.
- falu_start and falu_abort are never high in the same cycle.

## Test plan
- Reset, then add (L=3) request at cycle 0:
  - falu_start=1 at cycle 0 only
  - stall=1 for cycles 0-2
  - sel=0 and pend_rd=E_rd at cycle 3
  - state IDLE at cycle 4
  - stall_cycles=3
- Misc op (L=1):
  - stall=1 at cycle 0 only
  - DONE at cycle 1, never in RUN
- Div (L=12) with flush at cycle 5:
  - falu_abort=1 at cycle 5
  - stall=0 at cycle 5
  - IDLE at cycle 6
  - sel is never 0
- Mul at cycle 0, then add queued:
  - mul DONE at cycle 4
  - add falu_start at cycle 5
  - add DONE at cycle 8
  - stall_cycles=7
- req and flush together in IDLE: no start, stall=0, state remains IDLE.
- rst_n low at cycle 6 of a sqrt:
  - all outputs return to reset values asynchronously
  - after release, a new add issues normally

Source files
------------

// File: rtl/falu_issue_ctrl.sv
// Execute-stage sequencer for the multi-cycle FALU: issues an op, stalls the
// front of the pipe for its latency, then steers the FALU result for one cycle.
module falu_issue_ctrl #(
  parameter int LAT_ADD  = 3,
  parameter int LAT_MUL  = 4,
  parameter int LAT_DIV  = 12,
  parameter int LAT_SQRT = 16,
  parameter int LAT_MISC = 1,
  parameter int CNT_W    = 5
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        E_falu_req,
  input  logic [2:0]  E_falu_op,
  input  logic [4:0]  E_rd,
  input  logic        flush,
  output logic        falu_start,
  output logic [2:0]  falu_op_q,
  output logic        falu_abort,
  output logic        stall,
  output logic        E_alu_falu_sel,
  output logic        pend_valid,
  output logic [4:0]  pend_rd,
  output logic [31:0] stall_cycles
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state, state_nx;
  logic [CNT_W-1:0] cnt, cnt_nx, lat_m1;
  logic             issue;
  logic             abort;

  always_comb begin
    case (E_falu_op)
      3'b000, 3'b001: lat_m1 = CNT_W'(LAT_ADD - 1);
      3'b010:         lat_m1 = CNT_W'(LAT_MUL - 1);
      3'b011:         lat_m1 = CNT_W'(LAT_DIV - 1);
      3'b100:         lat_m1 = CNT_W'(LAT_SQRT - 1);
      default:        lat_m1 = CNT_W'(LAT_MISC - 1);
    endcase
  end

  // rst_n gating keeps start/stall low while reset is held, not just after an edge
  assign issue = (state == IDLE) && E_falu_req && !flush && rst_n;

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    abort    = 1'b0;
    case (state)
      IDLE: begin
        if (issue) begin
          cnt_nx   = lat_m1;
          state_nx = (lat_m1 != '0) ? RUN : DONE;
        end
      end
      RUN: begin
        if (flush) begin
          abort    = 1'b1;
          state_nx = IDLE;
        end else if (cnt == CNT_W'(1) || cnt == '0) begin
          state_nx = DONE;
        end else begin
          cnt_nx = cnt - CNT_W'(1);
        end
      end
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      cnt          <= '0;
      falu_op_q    <= '0;
      pend_rd      <= '0;
      stall_cycles <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      if (issue) begin
        falu_op_q <= E_falu_op;
        pend_rd   <= E_rd;
      end
      if (stall && stall_cycles != '1)
        stall_cycles <= stall_cycles + 32'd1;
    end
  end

  assign falu_start     = issue;
  assign falu_abort     = abort;
  assign stall          = issue || (state == RUN && !flush);
  assign E_alu_falu_sel = (state != DONE);
  assign pend_valid     = (state == RUN) || (state == DONE);

endmodule

// File: tb/tb_falu_issue_ctrl.sv
// Bench for falu_issue_ctrl: directed scenarios plus random traffic, checked
// against a cycle-count model of each in-flight operation.
module tb_falu_issue_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        E_falu_req;
  logic [2:0]  E_falu_op;
  logic [4:0]  E_rd;
  logic        flush;
  logic        falu_start;
  logic [2:0]  falu_op_q;
  logic        falu_abort;
  logic        stall;
  logic        E_alu_falu_sel;
  logic        pend_valid;
  logic [4:0]  pend_rd;
  logic [31:0] stall_cycles;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  // Reference model: an op issued at cycle t with latency L is "in flight";
  // m_p counts cycles since issue, and cycle t+L is its completion cycle.
  bit          m_busy;
  int          m_p;
  int          m_lat;
  logic [2:0]  m_op;
  logic [4:0]  m_rd;
  logic [31:0] m_stalls;
  int          lat_tab [8] = '{3, 3, 4, 12, 16, 1, 1, 1};

  falu_issue_ctrl #(
    .LAT_ADD (3),
    .LAT_MUL (4),
    .LAT_DIV (12),
    .LAT_SQRT(16),
    .LAT_MISC(1),
    .CNT_W   (5)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .E_falu_req    (E_falu_req),
    .E_falu_op     (E_falu_op),
    .E_rd          (E_rd),
    .flush         (flush),
    .falu_start    (falu_start),
    .falu_op_q     (falu_op_q),
    .falu_abort    (falu_abort),
    .stall         (stall),
    .E_alu_falu_sel(E_alu_falu_sel),
    .pend_valid    (pend_valid),
    .pend_rd       (pend_rd),
    .stall_cycles  (stall_cycles)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, observed=running required=finished");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  logic e_start, e_abort, e_stall, e_sel, e_pv;

  task automatic model_expect();
    e_start = 1'b0; e_abort = 1'b0; e_stall = 1'b0; e_sel = 1'b1; e_pv = 1'b0;
    if (rst_n) begin
      if (!m_busy) begin
        e_start = E_falu_req && !flush;
        e_stall = e_start;
      end else if (m_p < m_lat) begin
        e_stall = !flush;
        e_abort = flush;
        e_pv    = 1'b1;
      end else begin
        e_sel = 1'b0;
        e_pv  = 1'b1;
      end
    end
  endtask

  task automatic check_outputs();
    model_expect();
    chk("falu_start",     {31'd0, falu_start},     {31'd0, e_start});
    chk("falu_abort",     {31'd0, falu_abort},     {31'd0, e_abort});
    chk("stall",          {31'd0, stall},          {31'd0, e_stall});
    chk("E_alu_falu_sel", {31'd0, E_alu_falu_sel}, {31'd0, e_sel});
    chk("pend_valid",     {31'd0, pend_valid},     {31'd0, e_pv});
    chk("falu_op_q",      {29'd0, falu_op_q},      {29'd0, m_op});
    chk("pend_rd",        {27'd0, pend_rd},        {27'd0, m_rd});
    chk("stall_cycles",   stall_cycles,            m_stalls);
  endtask

  task automatic model_reset();
    m_busy = 0; m_p = 0; m_lat = 0; m_op = '0; m_rd = '0; m_stalls = '0;
  endtask

  task automatic model_advance();
    model_expect();
    if (e_stall && m_stalls != 32'hFFFF_FFFF) m_stalls = m_stalls + 32'd1;
    if (!m_busy) begin
      if (e_start) begin
        m_busy = 1; m_p = 1; m_lat = lat_tab[E_falu_op];
        m_op = E_falu_op; m_rd = E_rd;
      end
    end else if (m_p < m_lat && flush) begin
      m_busy = 0;
    end else if (m_p >= m_lat) begin
      m_busy = 0;
    end else begin
      m_p++;
    end
  endtask

  task automatic step(input logic req, input logic [2:0] op, input logic [4:0] rd, input logic fl);
    @(negedge clk);
    E_falu_req = req; E_falu_op = op; E_rd = rd; flush = fl;
    #1;
    check_outputs();
    model_advance();
  endtask

  // Hold the request until the op completes (or is killed); flush on cycle flush_cyc.
  task automatic run_op(input logic [2:0] op, input logic [4:0] rd, input int flush_cyc);
    for (int c = 0; c < 40; c++) begin
      step(1'b1, op, rd, c == flush_cyc);
      if (c > 0 && !m_busy) break;
    end
  endtask

  initial begin
    rst_n = 1'b0; E_falu_req = 1'b0; E_falu_op = '0; E_rd = '0; flush = 1'b0;
    model_reset();
    #2;
    check_outputs();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    run_op(3'b000, 5'd7, -1);          // add, L=3
    step(1'b0, 3'b000, 5'd0, 1'b0);
    run_op(3'b101, 5'd9, -1);          // misc, L=1
    run_op(3'b111, 5'd10, -1);         // illegal acts as misc
    run_op(3'b011, 5'd12, 5);          // div killed at cycle 5
    step(1'b0, 3'b000, 5'd0, 1'b0);
    run_op(3'b010, 5'd3, -1);          // mul then add back-to-back
    run_op(3'b000, 5'd4, -1);
    step(1'b1, 3'b001, 5'd20, 1'b1);   // req+flush in IDLE
    run_op(3'b001, 5'd21, -1);

    // sqrt interrupted by an asynchronous reset at cycle 6
    for (int c = 0; c < 6; c++) step(1'b1, 3'b100, 5'd30, 1'b0);
    @(negedge clk);
    E_falu_req = 1'b1; E_falu_op = 3'b100; E_rd = 5'd30; flush = 1'b0;
    #1;
    check_outputs();
    rst_n = 1'b0;
    model_reset();
    #1;
    check_outputs();
    @(negedge clk);
    rst_n = 1'b1;
    E_falu_req = 1'b0;
    run_op(3'b000, 5'd17, -1);

    for (int i = 0; i < 400; i++) begin
      step($urandom_range(3, 0) != 0, 3'($urandom_range(7, 0)),
           5'($urandom_range(31, 0)), $urandom_range(7, 0) == 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
